// File: rtl/clkmux_sel_ctrl.sv
// Select controller for a glitch-free two-input clock mux.
// Runs on a free reference clock, judges clka/clkb activity from toggle
// ticks over a fixed window, and only requests a switch to a source that
// is alive. Holds off further changes while the mux completes its handoff,
// and optionally fails over when the selected source stops.
module clkmux_sel_ctrl #(
  parameter int WINDOW        = 64,
  parameter int MIN_EDGES     = 4,
  parameter int SETTLE        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int AUTO_FAILOVER = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clka_tick,
  input  logic clkb_tick,
  input  logic req_valid,
  input  logic req_src,
  output logic req_ready,
  output logic select,
  output logic busy,
  output logic done,
  output logic err,
  output logic failover,
  output logic alive_a,
  output logic alive_b
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CNT_W = $clog2(MIN_EDGES + 1);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  // Edge counters stop at MIN_EDGES; anything beyond that is irrelevant.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic e);
    if (e && (c < CNT_W'(MIN_EDGES))) return c + CNT_W'(1);
    return c;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic                   r_hist_a;
  logic                   r_hist_b;
  logic                   w_edge_a;
  logic                   w_edge_b;

  logic [WIN_W-1:0] r_win_cnt;
  logic             w_win_last;
  logic             r_win_end;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] w_cnt_a_nxt;
  logic [CNT_W-1:0] w_cnt_b_nxt;
  logic             r_alive_a;
  logic             r_alive_b;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_select;
  logic             w_select_nxt;
  logic             r_target;
  logic             w_target_nxt;
  logic [SET_W-1:0] r_settle;
  logic [SET_W-1:0] w_settle_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_failover;
  logic             w_failover_nxt;
  logic             w_req_ready;
  logic             w_alive_cur;
  logic             w_alive_oth;
  logic             w_alive_tgt;
  logic             w_fo_trig;

  // Tick synchronizers plus one history flop; any change counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_hist_a <= 1'b0;
      r_hist_b <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], clka_tick};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], clkb_tick};
      r_hist_a <= r_sync_a[SYNC_STAGES-1];
      r_hist_b <= r_sync_b[SYNC_STAGES-1];
    end
  end

  assign w_edge_a    = r_sync_a[SYNC_STAGES-1] ^ r_hist_a;
  assign w_edge_b    = r_sync_b[SYNC_STAGES-1] ^ r_hist_b;
  assign w_win_last  = (r_win_cnt == WIN_W'(WINDOW - 1));
  assign w_cnt_a_nxt = f_sat_inc(r_cnt_a, w_edge_a);
  assign w_cnt_b_nxt = f_sat_inc(r_cnt_b, w_edge_b);

  // Activity window: an edge in the last cycle still counts for the closing
  // window; alive flags and the win_end strobe appear together one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_win_end <= 1'b0;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_alive_a <= 1'b0;
      r_alive_b <= 1'b0;
    end else begin
      r_win_end <= w_win_last;
      if (w_win_last) begin
        r_win_cnt <= '0;
        r_cnt_a   <= '0;
        r_cnt_b   <= '0;
        r_alive_a <= (w_cnt_a_nxt == CNT_W'(MIN_EDGES));
        r_alive_b <= (w_cnt_b_nxt == CNT_W'(MIN_EDGES));
      end else begin
        r_win_cnt <= r_win_cnt + WIN_W'(1);
        r_cnt_a   <= w_cnt_a_nxt;
        r_cnt_b   <= w_cnt_b_nxt;
      end
    end
  end

  assign w_alive_cur = r_select ? r_alive_b : r_alive_a;
  assign w_alive_oth = r_select ? r_alive_a : r_alive_b;
  assign w_alive_tgt = r_target ? r_alive_b : r_alive_a;
  assign w_fo_trig   = (AUTO_FAILOVER != 0) && r_win_end && !w_alive_cur && w_alive_oth;

  // State and registered outputs; everything returns to idle values on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_select   <= 1'b0;
      r_target   <= 1'b0;
      r_settle   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_failover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_select   <= w_select_nxt;
      r_target   <= w_target_nxt;
      r_settle   <= w_settle_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_failover <= w_failover_nxt;
    end
  end

  // Next-state logic: failover outranks a request in IDLE; the select output
  // only moves on the transition into SWITCH, which then blocks for SETTLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_select_nxt   = r_select;
    w_target_nxt   = r_target;
    w_settle_nxt   = r_settle;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_failover_nxt = 1'b0;
    w_req_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !w_fo_trig;
        if (w_fo_trig) begin
          w_select_nxt   = !r_select;
          w_failover_nxt = 1'b1;
          w_settle_nxt   = '0;
          w_state_nxt    = S_SWITCH;
        end else if (req_valid) begin
          if (req_src == r_select) begin
            w_done_nxt = 1'b1;
          end else begin
            w_target_nxt = req_src;
            w_state_nxt  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (r_win_end) begin
          if (w_alive_tgt) begin
            w_select_nxt = r_target;
            w_settle_nxt = '0;
            w_state_nxt  = S_SWITCH;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_SWITCH: begin
        if (r_settle == SET_W'(SETTLE - 1)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_settle_nxt = r_settle + SET_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_ready = w_req_ready;
  assign select    = r_select;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign failover  = r_failover;
  assign alive_a   = r_alive_a;
  assign alive_b   = r_alive_b;

endmodule

// File: tb/tb_clkmux_sel_ctrl.sv
// Directed bench for clkmux_sel_ctrl with WINDOW=64, MIN_EDGES=4, SETTLE=8.
// Cycle 0 is the first cycle after reset release, so win_end (not a port)
// is high in cycles 64, 128, 192, ... and that is where alive flags update.
module tb_clkmux_sel_ctrl;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic clka_tick = 1'b0;
  logic clkb_tick = 1'b0;
  logic req_valid = 1'b0;
  logic req_src   = 1'b0;
  logic req_ready;
  logic select;
  logic busy;
  logic done;
  logic err;
  logic failover;
  logic alive_a;
  logic alive_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit en_a  = 1'b1;
  bit en_b  = 1'b1;

  always #5 clk = ~clk;

  clkmux_sel_ctrl #(
    .WINDOW(64), .MIN_EDGES(4), .SETTLE(8), .SYNC_STAGES(2), .AUTO_FAILOVER(1)
  ) dut (
    .clk(clk), .rst(rst), .clka_tick(clka_tick), .clkb_tick(clkb_tick),
    .req_valid(req_valid), .req_src(req_src), .req_ready(req_ready),
    .select(select), .busy(busy), .done(done), .err(err),
    .failover(failover), .alive_a(alive_a), .alive_b(alive_b)
  );

  // Advance one clock; enabled ticks toggle every 2 cycles.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % 2 == 0) begin
      if (en_a) clka_tick = ~clka_tick;
      if (en_b) clkb_tick = ~clkb_tick;
    end
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    // Reset and first window
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
    #1;
    chk("rst_select", select, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_failover", failover, 1'b0);
    chk("rst_alive_a", alive_a, 1'b0);
    chk("rst_alive_b", alive_b, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    goto_cyc(63);
    chk("w0_alive_a_early", alive_a, 1'b0);
    goto_cyc(64);
    chk("w0_alive_a", alive_a, 1'b1);
    chk("w0_alive_b", alive_b, 1'b1);
    chk("w0_select", select, 1'b0);
    chk("w0_busy", busy, 1'b0);

    // Request for the already-selected source
    goto_cyc(70);
    req_valid = 1'b1; req_src = 1'b0;
    #1;
    chk("same_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk("same_done", done, 1'b1);
    chk("same_busy", busy, 1'b0);
    chk("same_select", select, 1'b0);
    step();
    chk("same_done_clr", done, 1'b0);

    // Switch to live clkb
    goto_cyc(80);
    req_valid = 1'b1; req_src = 1'b1;
    #1;
    chk("sw_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    #1;
    chk("sw_check_busy", busy, 1'b1);
    chk("sw_check_select", select, 1'b0);
    chk("sw_check_ready", req_ready, 1'b0);
    goto_cyc(128);
    chk("sw_winend_select", select, 1'b0);
    step();
    chk("sw_select", select, 1'b1);
    chk("sw_busy", busy, 1'b1);
    chk("sw_done_early", done, 1'b0);
    step();
    req_valid = 1'b1; req_src = 1'b0;
    #1;
    chk("sw_ignore_ready", req_ready, 1'b0);
    step();
    req_valid = 1'b0;
    chk("sw_hold_select", select, 1'b1);
    goto_cyc(136);
    chk("sw_done_136", done, 1'b0);
    chk("sw_busy_136", busy, 1'b1);
    step();
    chk("sw_done", done, 1'b1);
    chk("sw_done_busy", busy, 1'b0);
    chk("sw_done_select", select, 1'b1);
    step();
    chk("sw_done_clr", done, 1'b0);

    // clkb stops -> automatic failover to clka
    goto_cyc(140);
    en_b = 1'b0; clkb_tick = 1'b0;
    goto_cyc(192);
    chk("fo_alive_b_192", alive_b, 1'b1);
    chk("fo_select_192", select, 1'b1);
    chk("fo_failover_192", failover, 1'b0);
    goto_cyc(256);
    chk("fo_alive_b", alive_b, 1'b0);
    chk("fo_alive_a", alive_a, 1'b1);
    chk("fo_select_pre", select, 1'b1);
    req_valid = 1'b1; req_src = 1'b0;
    #1;
    chk("fo_req_ready", req_ready, 1'b0);
    step();
    req_valid = 1'b0;
    chk("fo_pulse", failover, 1'b1);
    chk("fo_select", select, 1'b0);
    chk("fo_busy", busy, 1'b1);
    chk("fo_done_early", done, 1'b0);
    step();
    chk("fo_pulse_clr", failover, 1'b0);
    goto_cyc(264);
    chk("fo_done_264", done, 1'b0);
    step();
    chk("fo_done", done, 1'b1);
    chk("fo_done_busy", busy, 1'b0);
    chk("fo_done_select", select, 1'b0);
    step();
    chk("fo_done_clr", done, 1'b0);

    // Request toward dead clkb is rejected
    goto_cyc(270);
    req_valid = 1'b1; req_src = 1'b1;
    #1;
    chk("err_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk("err_busy", busy, 1'b1);
    goto_cyc(320);
    chk("err_early", err, 1'b0);
    chk("err_alive_b", alive_b, 1'b0);
    step();
    chk("err_pulse", err, 1'b1);
    chk("err_busy_after", busy, 1'b0);
    chk("err_select", select, 1'b0);
    chk("err_no_done", done, 1'b0);
    step();
    chk("err_clr", err, 1'b0);
    chk("err_no_done2", done, 1'b0);

    // Reset in the middle of SWITCH
    goto_cyc(330);
    en_b = 1'b1;
    goto_cyc(384);
    chk("r6_alive_b", alive_b, 1'b1);
    goto_cyc(390);
    req_valid = 1'b1; req_src = 1'b1;
    #1;
    chk("r6_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    goto_cyc(449);
    chk("r6_select", select, 1'b1);
    goto_cyc(452);
    chk("r6_busy_pre", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    chk("r6_select_rst", select, 1'b0);
    chk("r6_busy_rst", busy, 1'b0);
    chk("r6_alive_b_rst", alive_b, 1'b0);
    chk("r6_failover_rst", failover, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("r6_no_done", done, 1'b0);
      chk("r6_no_err", err, 1'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
